// File: rtl/register_file_dumper.sv
// ---------------------------------------------------------------------------
// register_file_dumper
//
// Reader-side companion to register_file. On a start pulse it takes over the
// register file read port, walks the registers in index order and streams
// each one out as an (addr, data) word on a valid/ready interface. The
// register file write port is not touched, so writeback can continue.
//
// Ports
//   clk         in   1       clock, all state on posedge
//   rst         in   1       asynchronous, active-low reset
//   start       in   1       request a dump (sampled only when idle)
//   abort       in   1       terminate a dump in progress at the next posedge
//   busy        out  1       dump in progress (reading or sending)
//   done        out  1       one-cycle pulse after the last word is accepted
//   rf_rd_addr  out  ADDR_W  register file read address
//   rf_rd_data  in   N       register file read data (combinational read)
//   out_valid   out  1       out_addr/out_data/out_last valid
//   out_ready   in   1       consumer accepts the word when valid & ready
//   out_addr    out  ADDR_W  register index of the current word
//   out_data    out  N       captured register value
//   out_last    out  1       current word is register NUM_REGS-1
// ---------------------------------------------------------------------------
module register_file_dumper #(
   parameter int N        = 32,
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int SKIP_X0  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rf_rd_addr,
   input  logic [N-1:0]      rf_rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [N-1:0]      out_data,
   output logic              out_last
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_SEND,
      ST_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] LP_LAST_IDX  = ADDR_W'(NUM_REGS - 1);
   // x0 is hardwired zero in the core, so it is normally not worth dumping.
   localparam logic [ADDR_W-1:0] LP_FIRST_IDX = (SKIP_X0 != 0) ? ADDR_W'(1) : '0;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_idx;
   logic                r_out_valid;
   logic [ADDR_W-1:0]   r_out_addr;
   logic [N-1:0]        r_out_data;
   logic                r_out_last;
   logic                w_handshake;
   logic                w_walking;

   assign w_handshake = r_out_valid & out_ready;
   assign w_walking   = (r_state == ST_READ) | (r_state == ST_SEND);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_READ;
            end
         end
         ST_READ: begin
            if (abort) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            // Abort wins over the handshake; a word accepted on the abort
            // edge is still considered delivered by the consumer.
            if (abort) begin
               w_state_nxt = ST_IDLE;
            end else if (w_handshake) begin
               w_state_nxt = r_out_last ? ST_DONE : ST_READ;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Walk index and output word register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_idx       <= '0;
         r_out_valid <= 1'b0;
         r_out_addr  <= '0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_idx <= LP_FIRST_IDX;
               end
            end
            ST_READ: begin
               if (abort) begin
                  r_out_valid <= 1'b0;
               end else begin
                  // Snapshot of the register as seen through the read port
                  // this cycle; later writes to it are not reflected.
                  r_out_data  <= rf_rd_data;
                  r_out_addr  <= r_idx;
                  r_out_last  <= (r_idx == LP_LAST_IDX);
                  r_out_valid <= 1'b1;
               end
            end
            ST_SEND: begin
               if (abort) begin
                  r_out_valid <= 1'b0;
               end else if (w_handshake) begin
                  r_out_valid <= 1'b0;
                  // The last word ends the walk, so idx never wraps.
                  if (!r_out_last) begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign busy       = w_walking;
   assign done       = (r_state == ST_DONE);
   assign rf_rd_addr = w_walking ? r_idx : '0;
   assign out_valid  = r_out_valid;
   assign out_addr   = r_out_addr;
   assign out_data   = r_out_data;
   assign out_last   = r_out_last;

endmodule

// File: tb/tb_register_file_dumper.sv
// ---------------------------------------------------------------------------
// tb_register_file_dumper
//
// Two dumpers (SKIP_X0=1 and SKIP_X0=0) share a behavioural register file
// with one write port and a combinational read port per dumper. Expected
// words come from the bench's own copy of the register contents, taken as a
// snapshot when each dump starts and adjusted for writes the bench makes
// before a register is read.
// ---------------------------------------------------------------------------
module tb_register_file_dumper;

   logic        clk;
   logic        rst_n;

   logic        a_start, a_abort, a_busy, a_done;
   logic [4:0]  a_rd_addr;
   logic [31:0] a_rd_data;
   logic        a_out_valid, a_out_ready, a_out_last;
   logic [4:0]  a_out_addr;
   logic [31:0] a_out_data;

   logic        b_start, b_abort, b_busy, b_done;
   logic [4:0]  b_rd_addr;
   logic [31:0] b_rd_data;
   logic        b_out_valid, b_out_ready, b_out_last;
   logic [4:0]  b_out_addr;
   logic [31:0] b_out_data;

   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;

   logic [31:0] rf [32];
   logic [31:0] mem_model [32];

   int n_tests;
   int n_fail;

   register_file_dumper #(.N(32), .NUM_REGS(32), .ADDR_W(5), .SKIP_X0(1)) u_dut_a (
      .clk(clk), .rst(rst_n), .start(a_start), .abort(a_abort),
      .busy(a_busy), .done(a_done), .rf_rd_addr(a_rd_addr), .rf_rd_data(a_rd_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_addr(a_out_addr),
      .out_data(a_out_data), .out_last(a_out_last)
   );

   register_file_dumper #(.N(32), .NUM_REGS(32), .ADDR_W(5), .SKIP_X0(0)) u_dut_b (
      .clk(clk), .rst(rst_n), .start(b_start), .abort(b_abort),
      .busy(b_busy), .done(b_done), .rf_rd_addr(b_rd_addr), .rf_rd_data(b_rd_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_addr(b_out_addr),
      .out_data(b_out_data), .out_last(b_out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural register file: x0 reads zero, write lands at posedge, so a
   // read on the same edge as a write still sees the old value.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (wr_en && wr_addr != 5'd0) begin
         rf[wr_addr] <= wr_data;
      end
   end
   assign a_rd_data = rf[a_rd_addr];
   assign b_rd_data = rf[b_rd_addr];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rf_write(input logic [4:0] addr, input logic [31:0] data);
      wr_en   = 1'b1;
      wr_addr = addr;
      wr_data = data;
      if (addr != 5'd0) mem_model[addr] = data;
      step();
      wr_en = 1'b0;
   endtask

   // mode 0: plain dump; 1: rewrite x5 on its accept and x9 before its read;
   // 2: pulse start while busy.
   task automatic dump_a(input string tg, input bit rnd_ready, input int mode);
      logic [31:0] snap [32];
      int exp_addr, k, words;
      bit got_done;
      for (int i = 0; i < 32; i++) snap[i] = mem_model[i];
      exp_addr = 1; k = 0; words = 0; got_done = 0;
      a_start = 1'b1;
      step();
      a_start = 1'b0;
      check({tg, "_busy"}, 64'(a_busy), 64'd1);
      while (k < 400) begin
         wr_en   = 1'b0;
         a_start = 1'b0;
         if (a_done) begin
            got_done = 1;
            break;
         end
         a_out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (a_out_valid) begin
            check({tg, "_addr"}, 64'(a_out_addr), 64'(exp_addr));
            check({tg, "_data"}, 64'(a_out_data), 64'(snap[exp_addr]));
            check({tg, "_last"}, 64'(a_out_last), 64'(exp_addr == 31));
            if (a_out_ready) begin
               if (mode == 1 && exp_addr == 5) begin
                  wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
                  mem_model[5] = 32'hDEADBEEF;
               end
               if (mode == 1 && exp_addr == 6) begin
                  wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hC0FFEE09;
                  mem_model[9] = 32'hC0FFEE09;
                  snap[9] = 32'hC0FFEE09;
               end
               if (mode == 2 && exp_addr == 12) a_start = 1'b1;
               exp_addr++;
               words++;
            end
         end
         step();
         k++;
      end
      wr_en   = 1'b0;
      a_start = 1'b0;
      check({tg, "_done_seen"}, 64'(got_done), 64'd1);
      check({tg, "_words"}, 64'(words), 64'd31);
      if (!rnd_ready) check({tg, "_cycles"}, 64'(k), 64'd62);
      step();
      check({tg, "_done_1cyc"}, 64'(a_done), 64'd0);
      check({tg, "_idle_busy"}, 64'(a_busy), 64'd0);
   endtask

   // Run dumper A with ready high until it presents word `addr`, then hold
   // ready low so it stays in SEND with that word.
   task automatic park_a_at(input string tg, input int addr);
      bit found;
      found = 0;
      a_start = 1'b1;
      step();
      a_start = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (a_out_valid && a_out_addr == 5'(addr)) begin
            found = 1;
            a_out_ready = 1'b0;
            break;
         end
         a_out_ready = 1'b1;
         step();
      end
      check({tg, "_parked"}, 64'(found), 64'd1);
   endtask

   initial begin
      int exp_addr, words;
      bit got_done;
      n_tests = 0; n_fail = 0;
      rst_n = 1'b0;
      a_start = 0; a_abort = 0; a_out_ready = 0;
      b_start = 0; b_abort = 0; b_out_ready = 0;
      wr_en = 0; wr_addr = '0; wr_data = '0;
      for (int i = 0; i < 32; i++) mem_model[i] = '0;
      #2;
      check("rst_valid", 64'(a_out_valid), 64'd0);
      check("rst_busy", 64'(a_busy), 64'd0);
      check("rst_done", 64'(a_done), 64'd0);
      check("rst_addr", 64'(a_out_addr), 64'd0);
      check("rst_data", 64'(a_out_data), 64'd0);
      check("rst_last", 64'(a_out_last), 64'd0);
      check("rst_rdaddr", 64'(a_rd_addr), 64'd0);
      #21;
      rst_n = 1'b1;
      step();

      // 1: incrementing pattern, ready tied high
      for (int i = 1; i < 32; i++) rf_write(5'(i), 32'h1000 + i);
      dump_a("t1", 0, 0);

      // 2: dumper starting at x0
      b_out_ready = 1'b1;
      b_start = 1'b1;
      step();
      b_start = 1'b0;
      exp_addr = 0; words = 0; got_done = 0;
      for (int k = 0; k < 200; k++) begin
         if (b_done) begin
            got_done = 1;
            break;
         end
         if (b_out_valid) begin
            if (exp_addr == 0) check("t2_x0_data", 64'(b_out_data), 64'd0);
            check("t2_addr", 64'(b_out_addr), 64'(exp_addr));
            check("t2_data", 64'(b_out_data), 64'(mem_model[exp_addr]));
            check("t2_last", 64'(b_out_last), 64'(exp_addr == 31));
            exp_addr++;
            words++;
         end
         step();
      end
      check("t2_done_seen", 64'(got_done), 64'd1);
      check("t2_words", 64'(words), 64'd32);

      // 3: random contents, random backpressure
      for (int i = 1; i < 32; i++) rf_write(5'(i), $urandom);
      dump_a("t3", 1, 0);
      dump_a("t3b", 1, 0);

      // 4: snapshot semantics
      dump_a("t4", 0, 1);
      dump_a("t4_after", 1, 0);

      // 5: abort while parked in SEND at x7
      park_a_at("t5", 7);
      a_abort = 1'b1;
      step();
      a_abort = 1'b0;
      check("t5_valid", 64'(a_out_valid), 64'd0);
      check("t5_busy", 64'(a_busy), 64'd0);
      check("t5_done", 64'(a_done), 64'd0);
      step();
      check("t5_done_later", 64'(a_done), 64'd0);
      dump_a("t5_restart", 0, 0);

      // 6: async reset between edges while parked in SEND at x10
      park_a_at("t6", 10);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_valid", 64'(a_out_valid), 64'd0);
      check("t6_busy", 64'(a_busy), 64'd0);
      check("t6_addr", 64'(a_out_addr), 64'd0);
      check("t6_data", 64'(a_out_data), 64'd0);
      check("t6_rdaddr", 64'(a_rd_addr), 64'd0);
      #1;
      rst_n = 1'b1;
      step();
      dump_a("t6_startbusy", 0, 2);
      dump_a("t6_rand", 1, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
